// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: FSM states,
// stage write-enable bit positions and the canned write-enable patterns.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_MISS_I    = 3'd1,
    ST_MISS_D    = 3'd2,
    ST_MISS_BOTH = 3'd3,
    ST_DMA_GRANT = 3'd4
  } state_t;

  localparam int WE_PC  = 4;
  localparam int WE_ID  = 3;
  localparam int WE_EX  = 2;
  localparam int WE_MEM = 1;
  localparam int WE_WB  = 0;

  localparam logic [4:0] STALL_ALL   = 5'b00000;
  localparam logic [4:0] BUBBLE_EX   = (5'b1 << WE_MEM) | (5'b1 << WE_WB);
  localparam logic [4:0] STALL_FRONT = BUBBLE_EX | (5'b1 << WE_EX);
  localparam logic [4:0] RUN_ALL     = STALL_FRONT | (5'b1 << WE_ID) | (5'b1 << WE_PC);

  typedef struct packed {
    logic [4:0] we;
    logic       flush;
  } stall_t;

  function automatic stall_t mk_stall(input logic [4:0] we, input logic flush);
    stall_t s;
    s.we    = we;
    s.flush = flush;
    return s;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_fwd_select.sv
// Forward-source selector for one ID operand: nearest producer stage wins.
// Purely combinational, zero latency; no flow control.
module pipeline_stall_ctrl_fwd_select #(
  parameter int REG_AW    = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FSEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_AW-1:0]           src,
  input  logic                        use_src,
  input  logic [FWD_DEPTH*REG_AW-1:0] dest_bus,
  input  logic [FWD_DEPTH-1:0]        regwrite_vec,
  input  logic [FWD_DEPTH-1:0]        load_vec,
  output logic [FSEL_W-1:0]           sel,
  output logic                        load_hit
);

  // Walk from the oldest stage towards EX so the youngest match overwrites.
  always_comb begin
    sel      = '0;
    load_hit = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (use_src && regwrite_vec[k-1] &&
          (dest_bus[(k-1)*REG_AW +: REG_AW] == src)) begin
        sel      = FSEL_W'(k);
        load_hit = load_vec[k-1] && (k <= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard, cache-miss and DMA cycle-steal controller for the 5-stage core.
// Stage enables are combinational; bg/grant_cnt are registered (1 cycle).
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int REG_AW    = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FSEL_W    = $clog2(FWD_DEPTH + 1),
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [REG_AW-1:0]           rs,
  input  logic [REG_AW-1:0]           rt,
  input  logic                        use_rs,
  input  logic                        use_rt,
  input  logic [FWD_DEPTH*REG_AW-1:0] dest_bus,
  input  logic [FWD_DEPTH-1:0]        regwrite_vec,
  input  logic [FWD_DEPTH-1:0]        load_vec,
  input  logic                        halt_id,
  input  logic                        i_hit,
  input  logic                        d_req,
  input  logic                        d_hit,
  input  logic                        i_ready,
  input  logic                        d_ready,
  input  logic                        br,
  input  logic                        dma_end,
  output logic [4:0]                  stage_we,
  output logic                        flush_ex,
  output logic [FSEL_W-1:0]           fwd_a,
  output logic [FSEL_W-1:0]           fwd_b,
  output logic                        both_access,
  output logic                        bg,
  output logic [CNT_W-1:0]            grant_cnt
);

  state_t state;
  logic   si, sd;
  logic   load_hit_a, load_hit_b;
  logic   lu, dmiss, both_done;
  stall_t ctrl;

  pipeline_stall_ctrl_fwd_select #(
    .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .FSEL_W(FSEL_W)
  ) u_fwd_a (
    .src(rs), .use_src(use_rs), .dest_bus(dest_bus), .regwrite_vec(regwrite_vec),
    .load_vec(load_vec), .sel(fwd_a), .load_hit(load_hit_a)
  );

  pipeline_stall_ctrl_fwd_select #(
    .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .FSEL_W(FSEL_W)
  ) u_fwd_b (
    .src(rt), .use_src(use_rt), .dest_bus(dest_bus), .regwrite_vec(regwrite_vec),
    .load_vec(load_vec), .sel(fwd_b), .load_hit(load_hit_b)
  );

  assign lu        = load_hit_a || load_hit_b;
  assign dmiss     = d_req && !d_hit;
  assign both_done = (si || i_ready) && (sd || d_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      si        <= 1'b0;
      sd        <= 1'b0;
      bg        <= 1'b0;
      grant_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          // A request seen while busy is never latched; br must still be high here.
          if (dmiss) begin
            state <= ST_MISS_D;
          end else if (br) begin
            state     <= ST_DMA_GRANT;
            bg        <= 1'b1;
            grant_cnt <= '0;
          end else if (!i_hit) begin
            state <= ST_MISS_I;
          end
        end
        ST_MISS_I: begin
          if (dmiss) begin
            state <= ST_MISS_BOTH;
            si    <= i_ready;
          end else if (i_ready) begin
            state <= ST_RUN;
          end
        end
        ST_MISS_D: begin
          if (!i_hit) begin
            state <= ST_MISS_BOTH;
            sd    <= d_ready;
          end else if (d_ready) begin
            state <= ST_RUN;
          end
        end
        ST_MISS_BOTH: begin
          if (both_done) begin
            state <= ST_RUN;
            si    <= 1'b0;
            sd    <= 1'b0;
          end else begin
            if (i_ready) si <= 1'b1;
            if (d_ready) sd <= 1'b1;
          end
        end
        ST_DMA_GRANT: begin
          if (!(&grant_cnt)) grant_cnt <= grant_cnt + 1'b1;
          if (dma_end) begin
            state <= ST_RUN;
            bg    <= 1'b0;
          end
        end
        default: begin
          state <= ST_RUN;
          bg    <= 1'b0;
        end
      endcase
    end
  end

  // A miss state's completion cycle releases the whole pipe at once.
  always_comb begin
    ctrl = mk_stall(RUN_ALL, 1'b0);
    if (state == ST_MISS_BOTH) begin
      ctrl = mk_stall(both_done ? RUN_ALL : STALL_ALL, 1'b0);
    end else if (state == ST_MISS_D) begin
      ctrl = mk_stall((d_ready && i_hit) ? RUN_ALL : STALL_ALL, 1'b0);
    end else if (state == ST_RUN && dmiss) begin
      ctrl = mk_stall(STALL_ALL, 1'b0);
    end else if (state == ST_DMA_GRANT && (d_req || !i_hit)) begin
      ctrl = mk_stall(STALL_ALL, 1'b0);
    end else if (state == ST_MISS_I) begin
      ctrl = mk_stall(i_ready ? RUN_ALL : STALL_FRONT, 1'b1);
    end else if (state == ST_RUN && !i_hit) begin
      ctrl = mk_stall(STALL_FRONT, 1'b1);
    end else if (lu) begin
      ctrl = mk_stall(BUBBLE_EX, 1'b1);
    end else if (halt_id) begin
      ctrl = mk_stall(STALL_FRONT, 1'b0);
    end
  end

  assign stage_we    = ctrl.we;
  assign flush_ex    = ctrl.flush;
  assign both_access = (state == ST_MISS_BOTH) ||
                       (state == ST_DMA_GRANT && (!i_hit || d_req));

endmodule
